// File: rtl/pipe_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the 5-stage MIPS pipeline control unit:
//   - width of the per-stage stall vector
//   - stall vector encodings (bit0 pc, bit1 if, bit2 id, bit3 ex, bit4 mem,
//     bit5 wb)
//   - state encoding of the multi-cycle EX sequencer
// ---------------------------------------------------------------------------
package pipe_ctrl_pkg;

  localparam int STALL_W = 6;

  // Hold PC/IF/ID only: EX receives a bubble.
  localparam logic [STALL_W-1:0] StallNone = 6'b000000;
  localparam logic [STALL_W-1:0] StallId   = 6'b000111;
  // Hold PC/IF/ID/EX: MEM receives a bubble while EX keeps working.
  localparam logic [STALL_W-1:0] StallEx   = 6'b001111;

  typedef enum logic [1:0] {
    MC_IDLE = 2'd0,
    MC_RUN  = 2'd1,
    MC_LAST = 2'd2
  } mc_state_e;

endpackage : pipe_ctrl_pkg

// File: rtl/pipe_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_if
// Bundle of the pipeline-control request/response signals.
//   Requests (into the control unit):
//     stallreq_from_id  load-use hazard in ID (same-cycle)
//     ex_mc_start       EX issues a multi-cycle op this cycle
//     ex_mc_cycles      total EX occupancy N of that op
//     flush_req         flush request from exception/branch logic
//   Responses (from the control unit):
//     stall_o           per-stage hold vector
//     flush_o           one-cycle flush of all pipeline registers
//     mc_busy_o         sequencer is in MC_RUN
//     mc_last_o         final EX cycle of a multi-cycle op
//     perf_stall_cnt_o  stall-cycle performance counter
// Modports: master = pipeline side driving requests, slave = pipe_ctrl.
// ---------------------------------------------------------------------------
interface pipe_ctrl_if #(
  parameter int MC_CNT_W = 6,
  parameter int PERF_W   = 32
);
  import pipe_ctrl_pkg::*;

  logic                  stallreq_from_id;
  logic                  ex_mc_start;
  logic [MC_CNT_W-1:0]   ex_mc_cycles;
  logic                  flush_req;
  logic [STALL_W-1:0]    stall_o;
  logic                  flush_o;
  logic                  mc_busy_o;
  logic                  mc_last_o;
  logic [PERF_W-1:0]     perf_stall_cnt_o;

  modport master (
    output stallreq_from_id, ex_mc_start, ex_mc_cycles, flush_req,
    input  stall_o, flush_o, mc_busy_o, mc_last_o, perf_stall_cnt_o
  );

  modport slave (
    input  stallreq_from_id, ex_mc_start, ex_mc_cycles, flush_req,
    output stall_o, flush_o, mc_busy_o, mc_last_o, perf_stall_cnt_o
  );

endinterface : pipe_ctrl_if

// File: rtl/pipe_ctrl_mc_counter.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_mc_counter
// Loadable down-counter with zero flag used by the multi-cycle EX sequencer.
// Ports:
//   clk, rst     clock / synchronous active-high reset (clears the count)
//   load_i       load load_val_i (takes priority over dec_i)
//   load_val_i   value to load
//   dec_i        decrement by one (stops at zero)
//   zero_o       count is zero
// ---------------------------------------------------------------------------
module pipe_ctrl_mc_counter #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule : pipe_ctrl_mc_counter

// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl
// Central pipeline control unit of the 5-stage MIPS core. Merges the ID
// load-use stall, the EX multi-cycle sequencer (div, madd/msub) and flush
// requests into one per-stage stall vector and a flush pulse.
// Priority: flush > EX multi-cycle > ID load-use.
//
// An op of N cycles stalls EX for exactly N cycles (the issue cycle in IDLE
// plus N-1 cycles in MC_RUN); the cycle after that is MC_LAST, where EX
// drives its result and advances.
//
// Ports:
//   clk   system clock
//   rst   synchronous active-high reset; forces all outputs to 0
//   bus   pipe_ctrl_if.slave (requests in, stall/flush/status out)
//
// Build option: define PIPE_CTRL_PERF_EN to enable the saturating
// stall-cycle counter on perf_stall_cnt_o (counts cycles with stall_o[0]=1).
// Without it the output is tied to 0.
// ---------------------------------------------------------------------------
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MC_CNT_W = 6,
  parameter int PERF_W   = 32
) (
  input  logic          clk,
  input  logic          rst,
  pipe_ctrl_if.slave    bus
);

  mc_state_e            state_q;
  mc_state_e            state_d;
  logic                 cnt_load;
  logic [MC_CNT_W-1:0]  cnt_load_val;
  logic                 cnt_dec;
  logic                 cnt_zero;
  logic [STALL_W-1:0]   stall_raw;
  logic                 flush_raw;
  logic                 issue;

  pipe_ctrl_mc_counter #(
    .W (MC_CNT_W)
  ) u_mc_counter (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  // N=0 is a plain single-cycle op and never engages the sequencer.
  assign issue = (state_q == MC_IDLE) && bus.ex_mc_start && (bus.ex_mc_cycles != '0);

  always_comb begin
    state_d      = state_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    stall_raw    = StallNone;
    flush_raw    = 1'b0;

    if (bus.flush_req) begin
      // Flush aborts any op in flight; no MC_LAST is produced for it.
      flush_raw = 1'b1;
      state_d   = MC_IDLE;
    end else begin
      case (state_q)
        MC_IDLE: begin
          if (issue) begin
            stall_raw = StallEx;
            if (bus.ex_mc_cycles == MC_CNT_W'(1)) begin
              state_d = MC_LAST;
            end else begin
              // Issue cycle already counts as one stalled cycle, and the
              // zero count is one more MC_RUN cycle, hence N-2.
              state_d      = MC_RUN;
              cnt_load     = 1'b1;
              cnt_load_val = bus.ex_mc_cycles - MC_CNT_W'(2);
            end
          end else if (bus.stallreq_from_id) begin
            stall_raw = StallId;
          end
        end
        MC_RUN: begin
          // The EX hold pattern also covers any ID load-use request.
          stall_raw = StallEx;
          if (cnt_zero) begin
            state_d = MC_LAST;
          end else begin
            cnt_dec = 1'b1;
          end
        end
        MC_LAST: begin
          state_d = MC_IDLE;
          if (bus.stallreq_from_id) begin
            stall_raw = StallId;
          end
        end
        default: begin
          state_d = MC_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MC_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Reset masks every output, so a reset mid-op never shows a flush pulse.
  assign bus.stall_o   = rst ? StallNone : stall_raw;
  assign bus.flush_o   = rst ? 1'b0 : flush_raw;
  assign bus.mc_busy_o = !rst && (state_q == MC_RUN);
  assign bus.mc_last_o = !rst && (state_q == MC_LAST);

`ifdef PIPE_CTRL_PERF_EN
  logic [PERF_W-1:0] perf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_q <= '0;
    end else if (stall_raw[0] && (perf_q != '1)) begin
      perf_q <= perf_q + PERF_W'(1);
    end
  end

  assign bus.perf_stall_cnt_o = rst ? '0 : perf_q;
`else
  assign bus.perf_stall_cnt_o = '0;
`endif

  // Issuing a new multi-cycle op while the sequencer is not idle is a
  // protocol violation by the EX stage.
  a_no_reissue : assert property (
    @(posedge clk) disable iff (rst)
    (state_q != MC_IDLE) |-> !bus.ex_mc_start
  );

endmodule : pipe_ctrl

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline control unit for the 5-stage MIPS core.
- Merges the ID-stage load-use stall request, EX-stage multi-cycle operations (div, madd/msub) and flush requests into one per-stage stall vector and a flush pulse.
- Owns the multi-cycle EX sequencer: a counter-driven FSM that holds the EX stage until the operation completes, then signals the result cycle.

Parameters:
- MC_CNT_W, 6, width of the multi-cycle length input and counter (maximum 63 extra cycles).
- PERF_W, 32, width of the stall-cycle performance counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset (`RstEnable`)
- stallreq_from_id  in  1  load-use hazard in ID; combinational, same-cycle
- ex_mc_start  in  1  EX holds a multi-cycle op this cycle (issue cycle)
- ex_mc_cycles  in  MC_CNT_W  total EX-occupancy cycles N for that op; sampled when ex_mc_start=1
- flush_req  in  1  flush request from the exception/branch source
- stall_o  out  6  per-stage hold; bit0 pc, bit1 if, bit2 id, bit3 ex, bit4 mem, bit5 wb
- flush_o  out  1  one-cycle flush of all pipeline registers
- mc_busy_o  out  1  sequencer is in MC_RUN
- mc_last_o  out  1  final EX cycle of a multi-cycle op; EX drives its result and advances
- perf_stall_cnt_o  out  PERF_W  stall-cycle counter (see Optional Feature)

Behaviour:
- Reset (synchronous, rst=1 at posedge): FSM=IDLE, counter=0, perf counter=0.
- While rst=1, all outputs are forced to 0 combinationally.
- FSM states:
  - IDLE:
    - ex_mc_start=1 with N>=2 → MC_RUN, counter loaded with N-2.
    - ex_mc_start=1 with N=1 → MC_LAST.
    - N=0 means a single-cycle op: no stall, state unchanged.
  - MC_RUN:
    - counter=0 → MC_LAST.
    - Otherwise the counter decrements by 1.
  - MC_LAST: → IDLE unconditionally. mc_last_o=1 in this state only.
- Stall generation is combinational. Priority order is flush > EX > ID.
  - flush_req=1: flush_o=1, stall_o=6'b000000. The FSM goes to IDLE next cycle from any state.
  - EX stall: stall_o=6'b001111 when either
    - ex_mc_start=1 with N>=1 in IDLE, or
    - the FSM is in MC_RUN.
  - MC_LAST: EX is not stalled. stall_o is the ID term only.
  - ID stall: stallreq_from_id=1 with no higher-priority source gives stall_o=6'b000111. EX receives a bubble.
  - Otherwise: stall_o=0, flush_o=0.
- Timing consequence: an op with N cycles holds EX stalled for exactly N cycles (issue cycle plus N-1 in MC_RUN). The following cycle is MC_LAST.
- mc_busy_o=1 iff the state is MC_RUN. It does not include the issue cycle or MC_LAST.
- ex_mc_start is ignored outside IDLE. Re-issue while busy is a protocol violation, flagged by an assertion in simulation.
- ex_mc_cycles is sampled only in the IDLE issue cycle. Later changes have no effect.
- Flush mid-op aborts the op. mc_last_o is never produced for the aborted op.
- Simultaneous events:
  - flush_req with ex_mc_start: the flush wins and the op is not started.
  - stallreq_from_id during MC_RUN: absorbed by the EX stall pattern.
- Reset mid-op has the same effect as a flush with no flush_o pulse.

Optional Feature:
- Macro: PIPE_CTRL_PERF_EN.
- Defined:
  - perf_stall_cnt_o increments by 1 on every non-reset cycle where stall_o[0]=1.
  - It saturates at all-ones. It is cleared only by rst.
- Undefined: perf_stall_cnt_o is tied to 0 and no counter flops are inferred.

Decomposition:
- Shared macros file (the existing global defines):
  - stall vector width.
  - Encodings `StallNone`=6'b000000, `StallId`=6'b000111, `StallEx`=6'b001111.
  - FSM state encodings `MC_IDLE`, `MC_RUN`, `MC_LAST` (2 bits).
- One natural sub-module: mc_counter (loadable down-counter with zero flag), instantiated once.
- Stall merge logic stays inline.

Test Plan:
- Reset, then stallreq_from_id=1 for 1 cycle → stall_o=6'b000111 that cycle; 0 the next cycle; mc_busy_o=0.
- ex_mc_start=1 with ex_mc_cycles=4 in IDLE → stall_o=6'b001111 for 4 consecutive cycles; mc_busy_o=1 on cycles 2-4; mc_last_o=1 on cycle 5 with stall_o=0; IDLE on cycle 6.
- ex_mc_cycles=1 → 1 stall cycle, then mc_last_o next cycle. ex_mc_cycles=0 → no stall and no mc_last_o.
- Start a 34-cycle op; assert flush_req on cycle 10 → flush_o=1, stall_o=0 that cycle; IDLE next cycle; mc_last_o never asserted.
- flush_req and ex_mc_start together in IDLE → flush_o=1, stall_o=0, FSM stays IDLE.
- With PIPE_CTRL_PERF_EN: run the 4-cycle op plus 2 ID stalls → perf_stall_cnt_o=6. Without the macro → perf_stall_cnt_o remains 0. Assert rst mid-op → all outputs 0, counter cleared.
